switch_op_selector: RTL and testbench

- Registered, parametrised successor to the combinational switch-to-op decoder. It sits between the board mode switches and the top-level controller FSM.
- Synchronises and debounces a vector of NUM_SW mode switches, then validates that exactly one switch is set and encodes it to an op code.
- Commits the op code only while the downstream controller is not busy, and emits a one-cycle pulse on every committed change.

---
 rtl/switch_op_selector.sv | 121 ++++++++++++
 tb/tb_switch_op_selector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_op_selector.sv
// Mode-switch front end: synchronises and debounces the switch vector, decodes a
// one-hot selection to an op code and commits it only while the controller is idle.
module switch_op_selector #(
  parameter int NUM_SW          = 5,
  parameter int OP_W            = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw,
  input  logic              busy,
  output logic [OP_W-1:0]   op,
  output logic              op_valid,
  output logic              op_changed,
  output logic              sw_error,
  output logic              pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_SW-1:0] SW_ONE   = NUM_SW'(1);

  localparam logic [0:0] S_TRACK = 1'b0;
  localparam logic [0:0] S_LOCK  = 1'b1;

  logic [NUM_SW-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SW-1:0] r_cand;
  logic [NUM_SW-1:0] r_deb;
  logic [CNT_W-1:0]  r_cnt;
  logic [0:0]        r_state;
  logic [OP_W-1:0]   r_op;
  logic              r_opValid;
  logic              r_opChanged;
  logic              r_pending;

  logic [NUM_SW-1:0] w_swS;
  logic              w_multi;
  logic [OP_W-1:0]   w_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_swS = r_sync[SYNC_STAGES-1];

  // Any difference from the candidate restarts the count for the whole vector;
  // the counter parks at its last value so it can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_deb  <= '0;
    end else if (w_swS != r_cand) begin
      r_cand <= w_swS;
      r_cnt  <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_deb  <= r_cand;
    end else begin
      r_cnt  <= r_cnt + CNT_ONE;
    end
  end

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign w_multi = |(r_deb & (r_deb - SW_ONE));

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (r_deb[i]) w_dec = OP_W'(NUM_SW - i);
    end
    if (w_multi) w_dec = '0;
  end

  // Busy takes priority over a simultaneous decode change; the held difference
  // is committed on the first tracking cycle after busy drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_TRACK;
      r_op        <= '0;
      r_opValid   <= 1'b0;
      r_opChanged <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_opChanged <= 1'b0;
      case (r_state)
        S_TRACK: begin
          if (busy) begin
            r_state   <= S_LOCK;
            r_pending <= (w_dec != r_op);
          end else begin
            r_pending <= 1'b0;
            if (w_dec != r_op) begin
              r_op        <= w_dec;
              r_opValid   <= (w_dec != '0);
              r_opChanged <= 1'b1;
            end
          end
        end
        S_LOCK: begin
          r_pending <= (w_dec != r_op);
          if (!busy) r_state <= S_TRACK;
        end
        default: r_state <= S_TRACK;
      endcase
    end
  end

  assign op         = r_op;
  assign op_valid   = r_opValid;
  assign op_changed = r_opChanged;
  assign sw_error   = w_multi;
  assign pending    = r_pending;

endmodule

// File: tb/tb_switch_op_selector.sv
// Self-checking bench for switch_op_selector: directed sequences, a vector table
// and a randomized run, all cross-checked every cycle against a behavioural model.
module tb_switch_op_selector;

  localparam int NUM_SW          = 5;
  localparam int OP_W            = 3;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  // Clock edges from driving sw (between edges) to the pulse, counting the sampling edge.
  localparam int LAT_TICKS = SYNC_STAGES + DEBOUNCE_CYCLES + 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              busy  = 1'b0;
  logic [NUM_SW-1:0] sw    = '0;
  logic [OP_W-1:0]   op;
  logic              op_valid;
  logic              op_changed;
  logic              sw_error;
  logic              pending;

  int nChecks    = 0;
  int nFails     = 0;
  int pulseCount = 0;

  switch_op_selector #(
    .NUM_SW(NUM_SW), .OP_W(OP_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .busy(busy), .op(op), .op_valid(op_valid),
    .op_changed(op_changed), .sw_error(sw_error), .pending(pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: a value is accepted once seen on DEBOUNCE_CYCLES+1 consecutive
  // synchronised samples; op follows the decode unless busy holds it.
  logic [NUM_SW-1:0] mPipe [SYNC_STAGES];
  logic [NUM_SW-1:0] mRunVal = '0;
  int                mRunLen = 1;
  logic [NUM_SW-1:0] mDeb    = '0;
  logic [OP_W-1:0]   mOp     = '0;
  logic              mChanged = 1'b0;
  logic              mPending = 1'b0;
  logic              mLocked  = 1'b0;

  function automatic logic [OP_W-1:0] decodeRef(input logic [NUM_SW-1:0] v);
    if ($countones(v) != 1) return '0;
    for (int i = 0; i < NUM_SW; i++) if (v[i]) return OP_W'(NUM_SW - i);
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [OP_W-1:0]   dec;
    logic [NUM_SW-1:0] sample;
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) mPipe[i] = '0;
      mRunVal = '0; mRunLen = 1; mDeb = '0; mOp = '0;
      mChanged = 1'b0; mPending = 1'b0; mLocked = 1'b0;
    end else begin
      dec      = decodeRef(mDeb);
      sample   = mPipe[SYNC_STAGES-1];
      mChanged = 1'b0;
      if (!mLocked) begin
        if (busy) begin
          mLocked  = 1'b1;
          mPending = (dec != mOp);
        end else begin
          if (dec != mOp) begin
            mOp = dec;
            mChanged = 1'b1;
          end
          mPending = 1'b0;
        end
      end else begin
        mPending = (dec != mOp);
        if (!busy) mLocked = 1'b0;
      end
      if (sample == mRunVal) begin
        if (mRunLen <= DEBOUNCE_CYCLES) mRunLen++;
      end else begin
        mRunVal = sample;
        mRunLen = 1;
      end
      if (mRunLen >= DEBOUNCE_CYCLES + 1) mDeb = mRunVal;
      for (int i = SYNC_STAGES - 1; i > 0; i--) mPipe[i] = mPipe[i-1];
      mPipe[0] = sw;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (op_changed === 1'b1) pulseCount++;
    checkOutput("model.op",         32'(op),         32'(mOp));
    checkOutput("model.op_valid",   32'(op_valid),   32'(mOp != '0));
    checkOutput("model.op_changed", 32'(op_changed), 32'(mChanged));
    checkOutput("model.sw_error",   32'(sw_error),   32'($countones(mDeb) > 1));
    checkOutput("model.pending",    32'(pending),    32'(mPending));
  endtask

  task automatic applyStimulus(input logic [NUM_SW-1:0] swV, input logic busyV,
                               input logic rstnV, input int cycles);
    sw = swV;
    busy = busyV;
    rst_n = rstnV;
    repeat (cycles) stepCycle();
  endtask

  task automatic waitPulse(input string name);
    int n;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      stepCycle();
      if (op_changed === 1'b1) begin
        n = k;
        break;
      end
    end
    checkOutput(name, 32'(n), 32'(LAT_TICKS));
  endtask

  typedef struct {
    logic [NUM_SW-1:0] sw;
    logic              busy;
    int                hold;
    logic [OP_W-1:0]   expOp;
    logic              expValid;
    logic              expErr;
    logic              expPend;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{5'b10000, 1'b0, 12, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'b00100, 1'b0, 12, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{5'b00110, 1'b0, 12, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{5'b00001, 1'b0, 12, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'b00000, 1'b0, 12, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'b01000, 1'b0, 12, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{5'b01000, 1'b1,  3, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{5'b00010, 1'b1, 12, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{5'b00010, 1'b0, 12, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{5'b11111, 1'b0, 12, 3'd0, 1'b0, 1'b1, 1'b0};

    // Reset state and quiet release
    applyStimulus(5'b00000, 1'b0, 1'b0, 3);
    checkOutput("reset.op", 32'(op), 0);
    checkOutput("reset.op_valid", 32'(op_valid), 0);
    checkOutput("reset.op_changed", 32'(op_changed), 0);
    pulseCount = 0;
    applyStimulus(5'b00000, 1'b0, 1'b1, 20);
    checkOutput("release.pulses", 32'(pulseCount), 0);
    checkOutput("release.op", 32'(op), 0);

    // Single switch, exact latency and one-cycle pulse
    applyStimulus(5'b10000, 1'b0, 1'b1, 0);
    waitPulse("latency.sw4");
    checkOutput("sw4.op", 32'(op), 1);
    checkOutput("sw4.op_valid", 32'(op_valid), 1);
    stepCycle();
    checkOutput("sw4.pulseWidth", 32'(op_changed), 0);

    // Bounce never settles, then the final level is accepted
    pulseCount = 0;
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 5'b00001 : 5'b00000, 1'b0, 1'b1, 2);
    checkOutput("bounce.pulses", 32'(pulseCount), 0);
    checkOutput("bounce.opHeld", 32'(op), 1);
    applyStimulus(5'b00001, 1'b0, 1'b1, 0);
    waitPulse("latency.bounce");
    checkOutput("bounce.op", 32'(op), 5);

    // Multi-bit vector is an error and a real change to 0
    applyStimulus(5'b00110, 1'b0, 1'b1, 0);
    waitPulse("latency.multi");
    checkOutput("multi.op", 32'(op), 0);
    checkOutput("multi.op_valid", 32'(op_valid), 0);
    checkOutput("multi.sw_error", 32'(sw_error), 1);
    applyStimulus(5'b00100, 1'b0, 1'b1, 0);
    waitPulse("latency.sw2");
    checkOutput("sw2.op", 32'(op), 3);
    checkOutput("sw2.sw_error", 32'(sw_error), 0);

    // Busy holds op; commit one cycle after busy falls
    applyStimulus(5'b01000, 1'b0, 1'b1, 0);
    waitPulse("latency.sw3");
    applyStimulus(5'b01000, 1'b1, 1'b1, 1);
    pulseCount = 0;
    applyStimulus(5'b00010, 1'b1, 1'b1, 12);
    checkOutput("busy.opHeld", 32'(op), 2);
    checkOutput("busy.pending", 32'(pending), 1);
    checkOutput("busy.pulses", 32'(pulseCount), 0);
    applyStimulus(5'b00010, 1'b0, 1'b1, 1);
    checkOutput("busyFall.T.op", 32'(op), 2);
    checkOutput("busyFall.T.op_changed", 32'(op_changed), 0);
    stepCycle();
    checkOutput("busyFall.T1.op", 32'(op), 4);
    checkOutput("busyFall.T1.op_changed", 32'(op_changed), 1);
    checkOutput("busyFall.T1.pending", 32'(pending), 0);

    // Reset in the middle of a debounce discards progress
    applyStimulus(5'b10000, 1'b0, 1'b1, 0);
    waitPulse("latency.preReset");
    applyStimulus(5'b01000, 1'b0, 1'b1, 3);
    applyStimulus(5'b01000, 1'b0, 1'b0, 1);
    checkOutput("midReset.op", 32'(op), 0);
    checkOutput("midReset.op_valid", 32'(op_valid), 0);
    checkOutput("midReset.op_changed", 32'(op_changed), 0);
    checkOutput("midReset.sw_error", 32'(sw_error), 0);
    checkOutput("midReset.pending", 32'(pending), 0);
    applyStimulus(5'b01000, 1'b0, 1'b1, 0);
    waitPulse("latency.postReset");
    checkOutput("postReset.op", 32'(op), 2);

    // Table of settled states
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].sw, vecs[v].busy, 1'b1, vecs[v].hold);
      checkOutput($sformatf("vec%0d.op", v), 32'(op), 32'(vecs[v].expOp));
      checkOutput($sformatf("vec%0d.op_valid", v), 32'(op_valid), 32'(vecs[v].expValid));
      checkOutput($sformatf("vec%0d.sw_error", v), 32'(sw_error), 32'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d.pending", v), 32'(pending), 32'(vecs[v].expPend));
      checkOutput($sformatf("vec%0d.op_changed", v), 32'(op_changed), 0);
    end

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      logic [NUM_SW-1:0] nextSw;
      logic              nextBusy;
      logic              nextRstn;
      nextSw   = sw;
      nextBusy = busy;
      if ($urandom_range(0, 99) < 8) begin
        if ($urandom_range(0, 3) == 0) nextSw = NUM_SW'($urandom);
        else nextSw = NUM_SW'(1) << $urandom_range(0, NUM_SW - 1);
      end
      if ($urandom_range(0, 99) < 4) nextBusy = ~busy;
      nextRstn = ($urandom_range(0, 299) != 0);
      applyStimulus(nextSw, nextBusy, nextRstn, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
